// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder: valid/ready request, one fetch
// in flight, programmable wait states, range/alignment errors and flush.
module imem_fetch_responder #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WAIT  = 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Req,
  input  logic [31:0]   Addr,
  output logic          Ready,
  input  logic          Flush,
  output logic          RspValid,
  output logic [31:0]   Instr,
  output logic          RspErr,
  input  logic          RspAck,
  input  logic          PWe,
  input  logic [AW-1:0] PAddr,
  input  logic [31:0]   PData
);

  localparam logic [31:0] LAST = BASE + 32'(4 * DEPTH) - 32'd1;
  localparam logic [2:0] CNT_INIT =
    (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          vld_q;
  logic          err_q;
  logic [31:0]   instr_q;

  logic [31:0]   mem_q [DEPTH];

  logic          in_range;
  logic          accept;
  logic [AW-1:0] a_idx;

  assign in_range = (Addr >= BASE) && (Addr <= LAST) &&
                    (Addr[1:0] == 2'b00);
  assign a_idx    = AW'((Addr - BASE) >> 2);

  assign Ready  = !Flush &&
                  (state_q == S_IDLE ||
                   (state_q == S_RESP && RspAck));
  assign accept = Req && Ready;

  assign RspValid = vld_q;
  assign Instr    = instr_q;
  assign RspErr   = err_q;

  // Nonblocking write gives read-before-write on a same-edge collision.
  always_ff @(posedge Clk) begin
    if (PWe && (32'(PAddr) < DEPTH)) begin
      mem_q[PAddr] <= PData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= 32'd0;
    end else if (Flush) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
    end else if (accept) begin
      if (!in_range) begin
        state_q <= S_RESP;
        vld_q   <= 1'b1;
        err_q   <= 1'b1;
        instr_q <= 32'd0;
      end else if (WAIT == 0) begin
        state_q <= S_RESP;
        vld_q   <= 1'b1;
        err_q   <= 1'b0;
        instr_q <= mem_q[a_idx];
      end else begin
        state_q <= S_WAIT;
        vld_q   <= 1'b0;
        cnt_q   <= CNT_INIT;
        idx_q   <= a_idx;
      end
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q <= S_RESP;
            vld_q   <= 1'b1;
            err_q   <= 1'b0;
            instr_q <= mem_q[idx_q];
          end
        end
        S_RESP: begin
          if (RspAck) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench: three responders (WAIT=0,1,3) share stimulus and are
// compared each cycle against a transaction-level reference model.
module tb_imem_fetch_responder;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req = 1'b0;
  logic [31:0] Addr = 32'd0;
  logic        Flush = 1'b0;
  logic        RspAck = 1'b0;
  logic        PWe = 1'b0;
  logic [10:0] PAddr = 11'd0;
  logic [31:0] PData = 32'd0;

  logic        rdy [3];
  logic        vld [3];
  logic        err [3];
  logic [31:0] ins [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  imem_fetch_responder #(.WAIT(0)) u_w0 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Addr(Addr),
    .Ready(rdy[0]), .Flush(Flush), .RspValid(vld[0]),
    .Instr(ins[0]), .RspErr(err[0]), .RspAck(RspAck),
    .PWe(PWe), .PAddr(PAddr), .PData(PData)
  );

  imem_fetch_responder #(.WAIT(1)) u_w1 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Addr(Addr),
    .Ready(rdy[1]), .Flush(Flush), .RspValid(vld[1]),
    .Instr(ins[1]), .RspErr(err[1]), .RspAck(RspAck),
    .PWe(PWe), .PAddr(PAddr), .PData(PData)
  );

  imem_fetch_responder #(.WAIT(3)) u_w3 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Addr(Addr),
    .Ready(rdy[2]), .Flush(Flush), .RspValid(vld[2]),
    .Instr(ins[2]), .RspErr(err[2]), .RspAck(RspAck),
    .PWe(PWe), .PAddr(PAddr), .PData(PData)
  );

  // Reference: memory image plus one outstanding transaction per unit.
  logic [31:0] mem_m [2048];
  int          wst [3] = '{0, 1, 3};
  bit          pend [3];
  bit          mv [3];
  bit          me [3];
  logic [31:0] mi [3];
  int          left [3];
  int          midx [3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ok_addr(input logic [31:0] a);
    return a >= 32'h3000 && a <= 32'h4fff && a[1:0] == 2'b00;
  endfunction

  task automatic step(input bit rq, input logic [31:0] a,
                      input bit fl, input bit ak,
                      input bit we, input logic [10:0] pa,
                      input logic [31:0] pd, input bit rs);
    bit mrdy;
    int ai;
    Req = rq; Addr = a; Flush = fl; RspAck = ak;
    PWe = we; PAddr = pa; PData = pd; Rst = rs;
    @(negedge Clk);
    ai = int'((a - 32'h3000) >> 2);
    for (int k = 0; k < 3; k++) begin
      mrdy = !fl && ((!pend[k] && !mv[k]) || (mv[k] && ak));
      chk($sformatf("ready_w%0d", wst[k]), 32'(rdy[k]), 32'(mrdy));
      chk($sformatf("valid_w%0d", wst[k]), 32'(vld[k]), 32'(mv[k]));
      if (mv[k]) begin
        chk($sformatf("instr_w%0d", wst[k]), ins[k], mi[k]);
        chk($sformatf("err_w%0d", wst[k]), 32'(err[k]), 32'(me[k]));
      end
      if (rs) begin
        pend[k] = 0; mv[k] = 0; me[k] = 0; mi[k] = 0;
      end else if (fl) begin
        pend[k] = 0; mv[k] = 0;
      end else if (rq && mrdy) begin
        if (!ok_addr(a)) begin
          pend[k] = 0; mv[k] = 1; me[k] = 1; mi[k] = 0;
        end else if (wst[k] == 0) begin
          mv[k] = 1; me[k] = 0; mi[k] = mem_m[ai];
        end else begin
          pend[k] = 1; mv[k] = 0;
          left[k] = wst[k]; midx[k] = ai;
        end
      end else if (pend[k]) begin
        left[k]--;
        if (left[k] == 0) begin
          pend[k] = 0; mv[k] = 1; me[k] = 0;
          mi[k] = mem_m[midx[k]];
        end
      end else if (mv[k] && ak) begin
        mv[k] = 0;
      end
    end
    if (we) mem_m[pa] = pd;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ak);
    for (int i = 0; i < n; i++)
      step(0, 32'h0, 0, ak, 0, 11'd0, 32'd0, 0);
  endtask

  task automatic prog(input logic [10:0] pa, input logic [31:0] pd);
    step(0, 32'h0, 0, 0, 1, pa, pd, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; mv[k] = 0; me[k] = 0; mi[k] = 0;
      left[k] = 0; midx[k] = 0;
    end
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(vld[k]), 32'd0);
      chk("rst_instr", ins[k], 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_ready", 32'(rdy[k]), 32'd1);
    end

    prog(11'd0, 32'h3c01_1234);
    prog(11'd1, 32'h3421_5678);
    prog(11'd2, 32'h1111_1111);
    for (int i = 3; i < 16; i++) prog(11'(i), $urandom);
    prog(11'd2047, 32'hdead_beef);

    // WAIT=1 fetch, then hold without ack.
    step(1, 32'h3000, 0, 0, 0, 11'd0, 32'd0, 0);
    chk("w1_not_yet", 32'(vld[1]), 32'd0);
    idle(1, 0);
    chk("w1_valid", 32'(vld[1]), 32'd1);
    chk("w1_instr", ins[1], 32'h3c01_1234);
    chk("w1_err", 32'(err[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 0);
      chk("w1_hold", ins[1], 32'h3c01_1234);
    end
    idle(6, 1);

    // Back-to-back fetches at WAIT=0.
    step(1, 32'h3000, 0, 1, 0, 11'd0, 32'd0, 0);
    chk("b2b_0", ins[0], 32'h3c01_1234);
    chk("b2b_rdy0", 32'(rdy[0]), 32'd1);
    step(1, 32'h3004, 0, 1, 0, 11'd0, 32'd0, 0);
    chk("b2b_1", ins[0], 32'h3421_5678);
    chk("b2b_rdy1", 32'(rdy[0]), 32'd1);
    step(1, 32'h3008, 0, 1, 0, 11'd0, 32'd0, 0);
    chk("b2b_2", ins[0], 32'h1111_1111);
    chk("b2b_vld", 32'(vld[0]), 32'd1);
    idle(6, 1);

    // Error addresses skip wait states on every instance.
    foreach (wst[j]) begin end
    for (int j = 0; j < 3; j++) begin
      logic [31:0] ea;
      ea = (j == 0) ? 32'h2ffc : (j == 1) ? 32'h5000 : 32'h3002;
      step(1, ea, 0, 0, 0, 11'd0, 32'd0, 0);
      chk("err_vld_w3", 32'(vld[2]), 32'd1);
      chk("err_flag_w3", 32'(err[2]), 32'd1);
      chk("err_instr_w3", ins[2], 32'd0);
      idle(1, 1);
    end

    // Flush during WAIT=3 wait states.
    step(1, 32'h3004, 0, 0, 0, 11'd0, 32'd0, 0);
    idle(1, 0);
    step(1, 32'h3000, 1, 0, 0, 11'd0, 32'd0, 0);
    chk("flush_ready", 32'(rdy[2]), 32'd0);
    step(0, 32'h3000, 0, 0, 0, 11'd0, 32'd0, 0);
    chk("flush_idle_rdy", 32'(rdy[2]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_vld", 32'(vld[2]), 32'd0);
      idle(1, 0);
    end

    // Same-edge program write returns old word.
    step(1, 32'h3008, 0, 0, 1, 11'd2, 32'haaaa_aaaa, 0);
    chk("rbw_old", ins[0], 32'h1111_1111);
    idle(6, 1);
    step(1, 32'h3008, 0, 0, 0, 11'd0, 32'd0, 0);
    chk("rbw_new", ins[0], 32'haaaa_aaaa);
    idle(6, 1);

    // Reset while holding a response; memory survives.
    step(1, 32'h3000, 0, 0, 0, 11'd0, 32'd0, 0);
    chk("pre_rst_vld", 32'(vld[0]), 32'd1);
    step(0, 32'h0, 0, 0, 0, 11'd0, 32'd0, 1);
    chk("mid_rst_vld", 32'(vld[0]), 32'd0);
    chk("mid_rst_instr", ins[0], 32'd0);
    chk("mid_rst_err", 32'(err[0]), 32'd0);
    step(1, 32'h3000, 0, 0, 0, 11'd0, 32'd0, 0);
    chk("post_rst_instr", ins[0], 32'h3c01_1234);
    idle(6, 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'h3000 + 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'h4ffc;
      else if (r == 8) begin
        case ($urandom_range(0, 5))
          0: a = 32'h2ffc;
          1: a = 32'h5000;
          2: a = 32'h3002;
          3: a = 32'h3001;
          4: a = 32'h0;
          default: a = 32'hffff_fffc;
        endcase
      end else a = $urandom | 32'h8000_0000;
      step($urandom_range(0, 3) != 0, a,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? 11'd2047
                                       : 11'($urandom_range(0, 15)),
           $urandom,
           $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-memory responder on the fetch side of the pipeline: accepts PC fetch requests from the fetch stage over a valid/ready handshake and returns the 32-bit instruction word after a programmable number of wait states. It flags out-of-range or misaligned fetch addresses with an error response instead of reading memory. It holds at most one request in flight. Flush support lets exception and eret redirects cancel an outstanding fetch. Memory contents are loaded through a separate word-write program port.

## Interface
- BASE, 32'h0000_3000, byte address of word 0.
- DEPTH, 2048, number of 32-bit words; the valid range is BASE to BASE+4*DEPTH-1 (default 0x3000–0x4fff).
- WAIT, 1, wait-state cycles per in-range fetch; legal values 0–7.
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Req  input  1  fetch request valid.
- Addr  input  32  fetch byte address; sampled when the request is accepted.
- Ready  output  1  request accepted on this edge if Req=1 (combinational).
- Flush  input  1  cancel any in-flight or held fetch.
- RspValid  output  1  response held on Instr/RspErr.
- Instr  output  32  fetched instruction; 0 when RspErr=1.
- RspErr  output  1  fetch address out of range or Addr[1:0]≠0.
- RspAck  input  1  consumer takes the response.
- PWe  input  1  program-port write enable.
- PAddr  input  clog2(DEPTH)  program-port word index.
- PData  input  32  program-port write data.

## Operation
- States: IDLE, WAIT, RESP.
- Ready = !Flush & (state==IDLE | (state==RESP & RspAck)). A request is accepted when Req & Ready.
- Accept check: InRange = Addr>=BASE & Addr<=BASE+4*DEPTH-1 & Addr[1:0]==0. Word index = (Addr-BASE)>>2, truncated to clog2(DEPTH) bits.
- Accept with InRange=0: go to RESP with RspErr=1 and Instr=0. Wait states are skipped regardless of WAIT.
- Accept with InRange=1 and WAIT=0: go to RESP and register Instr=mem[index].
- Accept with InRange=1 and WAIT>0: go to WAIT with cnt=WAIT-1 and the index latched.
- WAIT: when cnt≠0, decrement cnt. When cnt==0, go to RESP and register Instr=mem[latched index] with RspErr=0.
- RESP: RspValid=1. Instr and RspErr stay stable until RspAck.
  - RspAck without a new accept: go to IDLE, RspValid=0 on the next cycle.
  - RspAck with a new accept: handle the new request exactly as an accept from IDLE (back-to-back fetch).
- Flush (any state): the next state is IDLE and RspValid=0 on the next cycle. Any held or pending response is discarded. Flush has priority over Req, RspAck and WAIT completion; Ready=0 while Flush=1.
- Program port: when PWe=1, mem[PAddr]<=PData on the edge. PAddr>=DEPTH is ignored. The port is independent of the state machine.
- Read/write collision: a program write on the same edge that registers Instr from the same word returns the old contents (read-before-write).
- Memory is not cleared by Rst.

## Timing
- Reset: after a Rst edge, state=IDLE, RspValid=0, RspErr=0, Instr=0, cnt=0. Ready=1 in the following cycle if Flush=0.
- Rst asserted mid-fetch (in WAIT or RESP) behaves the same as reset from IDLE. The in-flight response is dropped, never delivered.
- Latency for an in-range fetch: RspValid rises in the cycle after edge E0+WAIT, where E0 is the accepting edge. This is WAIT+1 cycles after the cycle Req was first sampled with Ready=1.
- Latency for an error fetch: RspValid rises in the cycle after E0.
- Throughput: with RspAck tied high, WAIT=0 and Req held, one instruction is delivered per cycle.
- With WAIT=N, at most one request completes per N+1 cycles.
- Addr is sampled only on the accepting edge. Changes to Addr while in WAIT or RESP have no effect.

## Test plan
- Reset, then PWe writes mem[0]=32'h3c01_1234 and mem[1]=32'h3421_5678. With WAIT=1, Req with Addr=0x3000 → RspValid=1 two cycles after acceptance, Instr=0x3c01_1234, RspErr=0. Hold the response without RspAck for 3 cycles → Instr stays stable.
- WAIT=0, Req held, RspAck=1, Addr stepping 0x3000, 0x3004, 0x3008 → three consecutive responses on consecutive cycles with the matching words and Ready=1 throughout.
- Addr=0x2ffc, Addr=0x5000 and Addr=0x3002 → each returns RspErr=1 and Instr=0 one cycle after acceptance, with no wait states.
- WAIT=3: accept 0x3004, then assert Flush in the second WAIT cycle → RspValid never rises and the state is IDLE next cycle. A Req with Flush=1 in the same cycle is not accepted (Ready=0).
- WAIT=0: PWe writes mem[2]=0xAAAA_AAAA on the same edge that accepts Addr=0x3008 (old value 0x1111_1111) → Instr=0x1111_1111. A re-fetch of 0x3008 → 0xAAAA_AAAA.
- Rst asserted while in RESP with an unacknowledged response → RspValid=0, Instr=0, RspErr=0 next cycle. Memory contents are retained: a fetch of 0x3000 still returns 0x3c01_1234.
